// File: rtl/seq_generator.sv
// Serial pattern transmitter: accepts WIDTH-bit words over valid/ready and shifts them out
// MSB-first, optionally followed by an idle gap, counting frames that match either target.
module seq_generator #(
  parameter int unsigned       WIDTH    = 6,
  parameter int unsigned       GAP      = 0,
  parameter logic              IDLE_BIT = 1'b0,
  parameter logic [WIDTH-1:0]  PAT_A    = WIDTH'(6'b111000),
  parameter logic [WIDTH-1:0]  PAT_B    = WIDTH'(6'b101110),
  parameter int unsigned       CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             data_out,
  output logic             data_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int unsigned CntBW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CntBW-1:0] CntLast = CntBW'(WIDTH - 1);
  localparam logic [GapW-1:0]  GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntBW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             match_q, match_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             accept, load;

  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      match_q       <= 1'b0;
      data_out_q    <= IDLE_BIT;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      hit_q         <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      match_q       <= match_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      hit_q         <= hit_d;
    end
  end

  always_comb begin : p_next
    accept        = in_valid && in_ready;
    load          = 1'b0;
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    match_d       = match_q;
    data_out_d    = IDLE_BIT;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    hit_d         = hit_q;

    unique case (state_q)
      StIdle: load = accept;
      StShift: begin
        if (cnt_q != '0) begin
          shreg_d      = shreg_q << 1;
          cnt_d        = cnt_q - CntBW'(1);
          data_out_d   = shreg_d[WIDTH-1];
          data_valid_d = 1'b1;
        end else if (accept) begin
          load = 1'b1;
        end else if (GAP > 0) begin
          state_d = StGap;
          gap_d   = GapLast;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GapW'(1);
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d       = StShift;
      shreg_d       = in_word;
      cnt_d         = CntLast;
      match_d       = (in_word == PAT_A) || (in_word == PAT_B);
      data_out_d    = in_word[WIDTH-1];
      data_valid_d  = 1'b1;
      frame_start_d = 1'b1;
    end

    // The edge that drives a frame's last bit also reports completion and counts the hit.
    if (data_valid_d && (cnt_d == '0)) begin
      frame_done_d = 1'b1;
      if (match_d && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
    end
  end

  always_comb begin : p_out
    in_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:  in_ready = 1'b1;
        StShift: in_ready = (GAP == 0) && (cnt_q == '0);
        StGap:   in_ready = (gap_q == '0);
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign hit_cnt     = hit_q;

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: two instances (GAP=0/CNT_W=8 and GAP=2/CNT_W=2) share one stimulus
// stream; each is compared every cycle against a frame-window reference model.
module tb_seq_generator;

  localparam int unsigned W = 6;
  localparam logic [W-1:0] PA = 6'b111000;
  localparam logic [W-1:0] PB = 6'b101110;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_word;
  logic [1:0]   rdy, dout, dval, fst, fdn, bsy;
  logic [7:0]   hit0;
  logic [1:0]   hit1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state per instance: current frame window, ready time, hit count.
  bit           act   [2];
  int           fstart[2];
  logic [W-1:0] fword [2];
  int           rfrom [2];
  int           hit   [2];
  bit           known = 1'b0;

  seq_generator #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0), .PAT_A(PA), .PAT_B(PB), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_word(in_word),
    .data_out(dout[0]), .data_valid(dval[0]), .frame_start(fst[0]), .frame_done(fdn[0]),
    .busy(bsy[0]), .hit_cnt(hit0)
  );

  seq_generator #(.WIDTH(W), .GAP(2), .IDLE_BIT(1'b0), .PAT_A(PA), .PAT_B(PB), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_word(in_word),
    .data_out(dout[1]), .data_valid(dval[1]), .frame_start(fst[1]), .frame_done(fdn[1]),
    .busy(bsy[1]), .hit_cnt(hit1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int max_hit(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  task automatic chk(input int i, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL dut%0d %s cycle %0d: got %0h expected %0h", i, tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check both instances mid-cycle, then advance the model.
  task automatic step(input bit r, input bit v, input logic [W-1:0] w);
    int  last, k;
    bit  inwin;
    logic [31:0] obs_hit;
    rst      = r;
    in_valid = v;
    in_word  = w;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      last  = fstart[i] + W - 1;
      inwin = act[i] && (cyc >= fstart[i]) && (cyc <= last);
      if (inwin && (cyc == last) && ((fword[i] == PA) || (fword[i] == PB)) &&
          (hit[i] < max_hit(i))) hit[i]++;
      chk(i, "in_ready", 32'(rdy[i]), 32'(!r && (cyc >= rfrom[i])));
      if (known) begin
        k = W - 1 - (cyc - fstart[i]);
        obs_hit = (i == 0) ? 32'(hit0) : 32'(hit1);
        chk(i, "data_valid", 32'(dval[i]), 32'(inwin));
        chk(i, "data_out", 32'(dout[i]), inwin ? 32'(fword[i][k]) : 32'd0);
        chk(i, "frame_start", 32'(fst[i]), 32'(inwin && (cyc == fstart[i])));
        chk(i, "frame_done", 32'(fdn[i]), 32'(inwin && (cyc == last)));
        chk(i, "busy", 32'(bsy[i]),
            32'(act[i] && (cyc >= fstart[i]) && (cyc <= last + gap_of(i))));
        chk(i, "hit_cnt", obs_hit, 32'(hit[i]));
      end
      if (r) begin
        act[i]   = 1'b0;
        hit[i]   = 0;
        rfrom[i] = cyc + 1;
      end else if (v && (cyc >= rfrom[i])) begin
        act[i]    = 1'b1;
        fstart[i] = cyc + 1;
        fword[i]  = w;
        rfrom[i]  = cyc + W + gap_of(i);
      end
    end
    if (r) known = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [W-1:0] rw;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; fstart[i] = 0; fword[i] = '0; rfrom[i] = 0; hit[i] = 0;
    end
    rst = 1'b1; in_valid = 1'b0; in_word = '0;
    @(posedge clk);
    #1;

    // Reset held with in_valid high.
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, PA);

    // Single matching frame.
    step(1'b0, 1'b1, PA);
    for (int n = 0; n < 9; n++) step(1'b0, 1'b0, '0);

    // Back-to-back frames with in_valid held high.
    for (int n = 0; n < 6; n++) step(1'b0, 1'b1, PB);
    for (int n = 0; n < 6; n++) step(1'b0, 1'b1, PA);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b0, '0);

    // Non-matching frame followed by a matching one; gap instance inserts idle cycles.
    step(1'b0, 1'b1, 6'b110011);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b1, PA);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b0, '0);

    // Reset after the third bit of a frame, then resend the same word.
    step(1'b0, 1'b1, PB);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PB);
    for (int n = 0; n < 9; n++) step(1'b0, 1'b0, '0);

    // Saturation on the 2-bit counter: several matching frames from a fresh reset.
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 42; n++) step(1'b0, 1'b1, PA);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b0, '0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 2))
        0:       rw = PA;
        1:       rw = PB;
        default: rw = W'($urandom);
      endcase
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, rw);
    end
    for (int n = 0; n < 10; n++) step(1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_generator.md
# seq_generator

Serial pattern transmitter that pairs with the 111000/101110 sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a serial line that drives the detector's data input. Between frames it can insert a configurable idle gap. It counts transmitted frames that equal either detector target, so benches and system tests can predict the detector's signal pulses.

## Interface
- WIDTH, 6: frame length in bits.
- GAP, 0: idle cycles inserted after each frame (0 = back-to-back streaming allowed).
- IDLE_BIT, 1'b0: level driven on data_out when no frame bit is being sent.
- PAT_A, 6'b111000: first target pattern (WIDTH bits).
- PAT_B, 6'b101110: second target pattern (WIDTH bits).
- CNT_W, 8: width of hit_cnt.

- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block can accept a word this cycle; combinational from state; forced 0 while rst=1.
- in_word  in  WIDTH  word to transmit; bit WIDTH-1 is sent first.
- data_out  out  1  serial output, registered.
- data_valid  out  1  data_out carries a frame bit, registered.
- frame_start  out  1  one-cycle pulse coincident with the first bit of a frame.
- frame_done  out  1  one-cycle pulse coincident with the last bit of a frame.
- busy  out  1  state != IDLE.
- hit_cnt  out  CNT_W  saturating count of completed frames equal to PAT_A or PAT_B.

## Operation
- **FSM states:** IDLE, SHIFT, GAP.
- **Accept:** a word is accepted when in_valid && in_ready is sampled at a clock edge.
- **At acceptance:**
  - Load the shift register.
  - Latch match = (in_word==PAT_A || in_word==PAT_B).
  - Set the bit counter to WIDTH-1.
  - Move to SHIFT.
- **in_ready:**
  - High in IDLE.
  - High in SHIFT during the last-bit cycle only when GAP==0.
  - High in GAP during its final cycle.
  - Low otherwise.
- **IDLE → SHIFT** on accept.
- **SHIFT:** one bit is output per cycle; the counter decrements.
  - On the last bit with an accept (GAP==0), reload and stay in SHIFT.
  - Else, if GAP>0, go to GAP.
  - Else go to IDLE.
- **GAP:** lasts exactly GAP cycles with data_out=IDLE_BIT and data_valid=0.
  - An accept in the final GAP cycle goes to SHIFT; otherwise go to IDLE.
- **hit_cnt:** increments by 1 on the edge that drives a frame's last bit, if match=1. It holds at all-ones and never wraps.
- **Abort:** only rst aborts a frame. in_word changes after acceptance have no effect.
- **Reset mid-frame:** the frame is dropped, not counted, and no frame_done is emitted.
- **Reset values:**
  - data_out=IDLE_BIT.
  - data_valid=0, frame_start=0, frame_done=0, busy=0.
  - hit_cnt=0; state=IDLE.
  - in_ready=0 during reset, 1 in the first cycle after rst falls.

## Timing
- **Latency:** a word accepted at edge k has its first bit on data_out after edge k, with data_valid=1 and frame_start=1 for that one cycle.
- **Bit order:** bit WIDTH-1-i is driven after edge k+i, for i=0..WIDTH-1. frame_done=1 and the hit_cnt update become visible after edge k+WIDTH-1.
- **GAP==0:** with in_valid held high, the next accept occurs at edge k+WIDTH. The serial stream has no bubble, data_valid stays 1, and frame_start is coincident with the cycle after the previous frame_done.
- **GAP>0:** the earliest next first bit appears after edge k+WIDTH+GAP.
- **Frame boundary:** frame_start and frame_done are never high in the same cycle for WIDTH>1.
- **Reset priority:** rst sampled high at any edge wins over an accept or count update at that same edge.
- **Detector alignment:** data_out is registered on clk, so the detector samples it directly with no extra staging.

## Test plan
- **Reset:** hold rst for 3 cycles with in_valid=1.
  - → in_ready=0 throughout; data_out=0, data_valid=0, hit_cnt=0.
  - → in_ready=1 in the first cycle after release.
- **Single frame, GAP=0:** accept 6'b111000.
  - → data_out = 1,1,1,0,0,0 on the next 6 cycles.
  - → frame_start on cycle 1, frame_done on cycle 6.
  - → hit_cnt becomes 1; then IDLE with data_out=0.
- **Back-to-back, GAP=0:** in_valid held high with 6'b101110 then 6'b111000.
  - → continuous 12-bit stream 101110111000 with data_valid=1 throughout.
  - → hit_cnt=2; in_ready high only in cycles 6 and 12 (plus idle).
- **Non-match plus gap, GAP=2:** send 6'b110011, then 6'b111000 with in_valid held high.
  - → 2 idle cycles (data_out=0, data_valid=0) between frames.
  - → hit_cnt increments only after the second frame (0→1).
- **Reset mid-frame:** assert rst after the 3rd bit of 6'b101110.
  - → data_out=0, busy=0, hit_cnt=0 after that edge; no frame_done.
  - → the next accepted 6'b101110 transmits fully and sets hit_cnt=1.
- **Saturation, CNT_W=2:** send 5 consecutive 6'b111000 frames.
  - → hit_cnt = 1,2,3,3,3.
